// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor
// Merges LAYER_COUNT sprite layers into the VGA pixel stream through a two
// stage pipeline (priority select, then channel expansion). The sync and
// video_on signals travel through matching registers so they stay aligned
// with the pixel. Each layer can also flash white for a number of frames,
// and overlaps between layer 0 (the player) and every other layer are
// collected per frame into coll_flags.
module vga_layer_compositor #(
    parameter int         LAYER_COUNT  = 8,
    parameter int         OUT_CH_W     = 4,
    parameter int         FLASH_FRAMES = 8,
    parameter logic [2:0] BG_RGB       = 3'b000
) (
    input  logic                     clk25,
    input  logic                     reset,
    input  logic [LAYER_COUNT-1:0]   layer_valid,
    input  logic [3*LAYER_COUNT-1:0] layer_rgb_flat,
    input  logic [LAYER_COUNT-1:0]   layer_en,
    input  logic [LAYER_COUNT-1:0]   flash_trig,
    input  logic                     video_on_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    output logic [OUT_CH_W-1:0]      vga_r,
    output logic [OUT_CH_W-1:0]      vga_g,
    output logic [OUT_CH_W-1:0]      vga_b,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     video_on,
    output logic [LAYER_COUNT-1:0]   coll_flags,
    output logic                     frame_tick
);

    // A zero-frame flash still needs a legal one-bit counter; it simply never loads.
    localparam int              CNT_W      = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);

    // Stage 1 registers: winning colour plus the first sync delay tap.
    logic [2:0]             rgbS1_q;
    logic [2:0]             rgbS1_d;
    logic                   hsyncS1_q;
    logic                   vsyncS1_q;
    logic                   videoOnS1_q;

    // Stage 2 registers drive the pins directly.
    logic [OUT_CH_W-1:0]    vgaR_q;
    logic [OUT_CH_W-1:0]    vgaG_q;
    logic [OUT_CH_W-1:0]    vgaB_q;
    logic                   hsync_q;
    logic                   vsync_q;
    logic                   videoOn_q;

    // Frame tick detection on the registered vsync.
    logic                   vsyncPrev_q;
    logic                   frameTick_q;

    // Flash counters, one per layer.
    logic [CNT_W-1:0]       flashCnt_q [LAYER_COUNT];
    logic [CNT_W-1:0]       flashCnt_d [LAYER_COUNT];
    logic [2:0]             effRgb     [LAYER_COUNT];

    // Collision accumulation for the frame in progress and the published result.
    logic [LAYER_COUNT-1:0] collHit;
    logic [LAYER_COUNT-1:0] collAcc_q;
    logic [LAYER_COUNT-1:0] collAcc_d;
    logic [LAYER_COUNT-1:0] collFlags_q;

    // A layer shows white on odd, non-zero flash counts, otherwise its own colour.
    always_comb begin
        for (int i = 0; i < LAYER_COUNT; i++) begin
            effRgb[i] = layer_rgb_flat[3*i +: 3];
            if (flashCnt_q[i] != '0 && flashCnt_q[i][0]) begin
                effRgb[i] = 3'b111;
            end
        end
    end

    // Lowest-index enabled valid layer wins; scanning downwards lets it overwrite the rest.
    always_comb begin
        rgbS1_d = BG_RGB;
        for (int i = LAYER_COUNT - 1; i >= 0; i--) begin
            if (layer_valid[i] && layer_en[i]) begin
                rgbS1_d = effRgb[i];
            end
        end
    end

    // Trigger reloads the count (beating a simultaneous frame tick), otherwise frame ticks count down.
    always_comb begin
        for (int i = 0; i < LAYER_COUNT; i++) begin
            flashCnt_d[i] = flashCnt_q[i];
            if (FLASH_FRAMES == 0) begin
                flashCnt_d[i] = '0;
            end else if (flash_trig[i]) begin
                flashCnt_d[i] = FLASH_LOAD;
            end else if (frameTick_q && flashCnt_q[i] != '0) begin
                flashCnt_d[i] = flashCnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Overlap between the player and each other layer; bit 0 never records anything.
    always_comb begin
        collHit = '0;
        for (int j = 1; j < LAYER_COUNT; j++) begin
            collHit[j] = video_on_in && layer_valid[0] && layer_en[0]
                         && layer_valid[j] && layer_en[j];
        end
    end

    // On a frame tick the accumulator restarts from this cycle's hits instead of being lost.
    always_comb begin
        collAcc_d = collAcc_q | collHit;
        if (frameTick_q) begin
            collAcc_d = collHit;
        end
    end

    // Stage 1: latch the selected colour and the first sync delay.
    always_ff @(posedge clk25) begin
        if (reset) begin
            rgbS1_q     <= 3'b000;
            hsyncS1_q   <= 1'b1;
            vsyncS1_q   <= 1'b1;
            videoOnS1_q <= 1'b0;
        end else begin
            rgbS1_q     <= rgbS1_d;
            hsyncS1_q   <= hsync_in;
            vsyncS1_q   <= vsync_in;
            videoOnS1_q <= video_on_in;
        end
    end

    // Stage 2: expand each colour bit to a full channel, blanked outside the visible area.
    always_ff @(posedge clk25) begin
        if (reset) begin
            vgaR_q    <= '0;
            vgaG_q    <= '0;
            vgaB_q    <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            videoOn_q <= 1'b0;
        end else begin
            vgaR_q    <= videoOnS1_q ? {OUT_CH_W{rgbS1_q[2]}} : '0;
            vgaG_q    <= videoOnS1_q ? {OUT_CH_W{rgbS1_q[1]}} : '0;
            vgaB_q    <= videoOnS1_q ? {OUT_CH_W{rgbS1_q[0]}} : '0;
            hsync_q   <= hsyncS1_q;
            vsync_q   <= vsyncS1_q;
            videoOn_q <= videoOnS1_q;
        end
    end

    // Frame tick fires on the 1->0 transition of the registered vsync.
    always_ff @(posedge clk25) begin
        if (reset) begin
            vsyncPrev_q <= 1'b1;
            frameTick_q <= 1'b0;
        end else begin
            vsyncPrev_q <= vsyncS1_q;
            frameTick_q <= vsyncPrev_q && !vsyncS1_q;
        end
    end

    // Flash counters keep running even for disabled layers.
    always_ff @(posedge clk25) begin
        if (reset) begin
            for (int i = 0; i < LAYER_COUNT; i++) begin
                flashCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAYER_COUNT; i++) begin
                flashCnt_q[i] <= flashCnt_d[i];
            end
        end
    end

    // Collision accumulator, published to coll_flags on every frame tick.
    always_ff @(posedge clk25) begin
        if (reset) begin
            collAcc_q   <= '0;
            collFlags_q <= '0;
        end else begin
            collAcc_q <= collAcc_d;
            if (frameTick_q) begin
                collFlags_q <= collAcc_q;
            end
        end
    end

    assign vga_r      = vgaR_q;
    assign vga_g      = vgaG_q;
    assign vga_b      = vgaB_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = videoOn_q;
    assign coll_flags = collFlags_q;
    assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Testbench for vga_layer_compositor: short synthetic frames, directed
// scenarios with literal expectations, then randomized layer traffic, all
// compared every cycle against a behavioural model of the compositor.
module tb_vga_layer_compositor;

    localparam int LC    = 8;
    localparam int CW    = 4;
    localparam int FF    = 8;
    localparam int FRAME = 30;

    logic              clk25 = 1'b0;
    logic              reset;
    logic [LC-1:0]     layer_valid;
    logic [3*LC-1:0]   layer_rgb_flat;
    logic [LC-1:0]     layer_en;
    logic [LC-1:0]     flash_trig;
    logic              video_on_in;
    logic              hsync_in;
    logic              vsync_in;
    logic [CW-1:0]     vga_r;
    logic [CW-1:0]     vga_g;
    logic [CW-1:0]     vga_b;
    logic              hsync;
    logic              vsync;
    logic              video_on;
    logic [LC-1:0]     coll_flags;
    logic              frame_tick;

    vga_layer_compositor #(
        .LAYER_COUNT (LC),
        .OUT_CH_W    (CW),
        .FLASH_FRAMES(FF),
        .BG_RGB      (3'b000)
    ) dut (
        .clk25         (clk25),
        .reset         (reset),
        .layer_valid   (layer_valid),
        .layer_rgb_flat(layer_rgb_flat),
        .layer_en      (layer_en),
        .flash_trig    (flash_trig),
        .video_on_in   (video_on_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .vga_r         (vga_r),
        .vga_g         (vga_g),
        .vga_b         (vga_b),
        .hsync         (hsync),
        .vsync         (vsync),
        .video_on      (video_on),
        .coll_flags    (coll_flags),
        .frame_tick    (frame_tick)
    );

    // 25 MHz pixel clock.
    always #20 clk25 = ~clk25;

    int checkCount = 0;
    int passCount  = 0;
    bit compareEn  = 1'b0;

    typedef struct {
        bit [CW-1:0] r;
        bit [CW-1:0] g;
        bit [CW-1:0] b;
        bit          hs;
        bit          vs;
        bit          von;
    } outEntry_t;

    // Model state: history of what each input cycle should produce at the pins,
    // plus flash counts, collision accumulator, published flags and tick.
    outEntry_t hist[$];
    int        mCnt[LC];
    bit        mTick;
    bit [LC-1:0] mAcc;
    bit [LC-1:0] mFlags;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic outEntry_t resetEntry();
        outEntry_t e;
        e.r = '0; e.g = '0; e.b = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0;
        return e;
    endfunction

    // Behavioural model: what the pins show after this edge is what the inputs
    // one edge earlier asked for; the tick marks the delayed vsync falling.
    always @(posedge clk25) begin : modelUpdate
        outEntry_t   e;
        bit [2:0]    col;
        int          win;
        bit [LC-1:0] hit;
        if (reset) begin
            hist.delete();
            repeat (3) hist.push_back(resetEntry());
            for (int i = 0; i < LC; i++) mCnt[i] = 0;
            mTick  = 1'b0;
            mAcc   = '0;
            mFlags = '0;
        end else begin
            win = -1;
            for (int i = LC - 1; i >= 0; i--)
                if (layer_valid[i] && layer_en[i]) win = i;
            col = 3'b000;
            if (win >= 0) col = (mCnt[win] % 2 == 1) ? 3'b111 : layer_rgb_flat[3*win +: 3];
            e.r   = (video_on_in && col[2]) ? {CW{1'b1}} : '0;
            e.g   = (video_on_in && col[1]) ? {CW{1'b1}} : '0;
            e.b   = (video_on_in && col[0]) ? {CW{1'b1}} : '0;
            e.hs  = hsync_in;
            e.vs  = vsync_in;
            e.von = video_on_in;
            hist.push_back(e);
            if (hist.size() > 8) void'(hist.pop_front());

            for (int i = 0; i < LC; i++) begin
                if (flash_trig[i]) mCnt[i] = FF;
                else if (mTick && mCnt[i] > 0) mCnt[i] = mCnt[i] - 1;
            end

            hit = '0;
            for (int j = 1; j < LC; j++)
                hit[j] = video_on_in && layer_valid[0] && layer_en[0] && layer_valid[j] && layer_en[j];
            if (mTick) begin
                mFlags = mAcc;
                mAcc   = hit;
            end else begin
                mAcc = mAcc | hit;
            end

            mTick = (hist[hist.size()-2].vs == 1'b0) && (hist[hist.size()-3].vs == 1'b1);
        end
    end

    // Single compare process, sampling away from the active edge.
    always @(negedge clk25) begin : compareProc
        outEntry_t x;
        if (compareEn && hist.size() >= 3) begin
            x = hist[hist.size()-2];
            checkOutput("pixel", {20'd0, vga_r, vga_g, vga_b}, {20'd0, x.r, x.g, x.b});
            checkOutput("sync", {29'd0, hsync, vsync, video_on}, {29'd0, x.hs, x.vs, x.von});
            checkOutput("collFlags", {24'd0, coll_flags}, {24'd0, mFlags});
            checkOutput("frameTick", {31'd0, frame_tick}, {31'd0, mTick});
        end
    end

    // Drive the synthetic raster position p, then advance one clock.
    task automatic applyStimulus(input int p);
        vsync_in    = !(p >= 24 && p < 26);
        hsync_in    = !((p % 8) >= 6);
        video_on_in = (p < 20) && ((p % 8) < 6);
        @(posedge clk25);
        @(negedge clk25);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "Pix"}, {20'd0, vga_r, vga_g, vga_b}, 32'h0);
        checkOutput({name, "Sync"}, {28'd0, hsync, vsync, video_on, frame_tick}, 32'hC);
        checkOutput({name, "Coll"}, {24'd0, coll_flags}, 32'h0);
    endtask

    initial begin
        logic [LC-1:0] trigBit;
        int expCnt;
        reset          = 1'b1;
        layer_valid    = '0;
        layer_en       = '1;
        flash_trig     = '0;
        layer_rgb_flat = '0;
        video_on_in    = 1'b0;
        hsync_in       = 1'b1;
        vsync_in       = 1'b1;
        @(negedge clk25);
        applyStimulus(0);
        applyStimulus(0);
        compareEn = 1'b1;
        checkResetOutputs("reset");
        reset = 1'b0;

        // Priority, enable and blanking with literal expectations.
        layer_rgb_flat[3 +: 3] = 3'b100;
        layer_rgb_flat[6 +: 3] = 3'b010;
        layer_valid = 8'b0000_0110;
        applyStimulus(0);
        applyStimulus(1);
        checkOutput("prioRed", {20'd0, vga_r, vga_g, vga_b}, 32'hF00);
        layer_en[1] = 1'b0;
        applyStimulus(2);
        applyStimulus(3);
        checkOutput("enableGreen", {20'd0, vga_r, vga_g, vga_b}, 32'h0F0);
        layer_en    = '1;
        layer_valid = '0;
        applyStimulus(4);
        applyStimulus(5);
        checkOutput("noValid", {20'd0, vga_r, vga_g, vga_b}, 32'h000);
        layer_valid = 8'b0000_0110;
        applyStimulus(6);
        applyStimulus(7);
        checkOutput("blanked", {20'd0, vga_r, vga_g, vga_b}, 32'h000);
        layer_valid = '0;
        for (int p = 8; p < FRAME; p++) begin
            applyStimulus(p);
            if (p == 24) checkOutput("vsyncStillHigh", {31'd0, vsync}, 32'h1);
            if (p == 25) checkOutput("vsyncLow", {31'd0, vsync}, 32'h0);
            if (p == 25) checkOutput("tickHigh", {31'd0, frame_tick}, 32'h1);
            if (p == 26) checkOutput("tickOneCycle", {31'd0, frame_tick}, 32'h0);
            if (p == 28) checkOutput("vsyncBack", {31'd0, vsync}, 32'h1);
        end

        // One-pixel overlap of layers 0 and 3 in one frame, none in the next.
        for (int p = 0; p < FRAME; p++) begin
            layer_valid = (p == 2) ? 8'b0000_1001 : 8'b0;
            applyStimulus(p);
            if (p == FRAME - 1) checkOutput("collSet", {24'd0, coll_flags}, 32'h08);
        end
        layer_valid = '0;
        for (int p = 0; p < FRAME; p++) begin
            applyStimulus(p);
            if (p == FRAME - 1) checkOutput("collCleared", {24'd0, coll_flags}, 32'h00);
        end

        // Flash layer 2 for FF frames: white while the remaining count is odd.
        layer_valid = 8'b0000_0100;
        for (int f = 0; f < FF + 2; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                flash_trig = (f == 0 && p == 0) ? 8'b0000_0100 : 8'b0;
                applyStimulus(p);
                if (p == 4) begin
                    expCnt = (FF - f > 0) ? FF - f : 0;
                    checkOutput("modelFlashCnt", mCnt[2], expCnt);
                    checkOutput("flashPix", {20'd0, vga_r, vga_g, vga_b},
                                (expCnt % 2 == 1) ? 32'hFFF : 32'h0F0);
                end
            end
        end

        // Trigger in the same cycle as the frame tick: the load wins.
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                flash_trig = (f == 0 && p == 26) ? 8'b0000_0100 : 8'b0;
                if (f == 0 && p == 26) checkOutput("tickWithTrig", {31'd0, frame_tick}, 32'h1);
                applyStimulus(p);
                if (f == 0 && p == 27) checkOutput("modelLoadWins", mCnt[2], FF);
                if (f == 1 && p == 4) checkOutput("loadWinsPix", {20'd0, vga_r, vga_g, vga_b}, 32'h0F0);
                if (f == 2 && p == 4) checkOutput("afterLoadPix", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);
            end
        end
        flash_trig = '0;

        // Randomized layer traffic, with one reset dropped in mid-line.
        for (int f = 0; f < 8; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                layer_valid    = LC'($urandom);
                layer_en       = LC'($urandom | $urandom);
                layer_rgb_flat = (3*LC)'($urandom);
                trigBit        = LC'(1) << $urandom_range(0, LC - 1);
                flash_trig     = ($urandom_range(0, 15) == 0) ? trigBit : '0;
                reset          = (f == 4 && p == 13);
                applyStimulus(p);
                if (f == 4 && p == 13) checkResetOutputs("midReset");
            end
        end
        reset      = 1'b0;
        flash_trig = '0;
        applyStimulus(0);
        applyStimulus(1);
        compareEn = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
